lstm_matvec_engine: RTL and testbench

Parametrised, streaming matrix-vector multiply-accumulate engine for the LSTM PE: computes result = W·x + b in signed fixed point. A bank of LANES multiply-accumulate lanes processes OUT_LEN/LANES row tiles sequentially. The input vector is buffered once and reused across tiles. Weights and bias are streamed in, and each tile's result is streamed out with valid/ready handshakes. It sits between the LSTM weight/activation memories and the gate nonlinearity stage.

---
 rtl/lstm_matvec_engine_if.sv | 33 +++
 rtl/lstm_matvec_engine.sv | 148 ++++++++++++++
 tb/tb_lstm_matvec_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_matvec_engine_if.sv
// Stream/control bundle for lstm_matvec_engine: vector, weight/bias and result
// handshakes plus job control.
interface lstm_matvec_engine_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 20,
    parameter int IDX_W  = 5
);
    logic                      start;
    logic                      reuse_vec;
    logic                      busy;
    logic                      done;
    logic                      vec_valid;
    logic                      vec_ready;
    logic [DATA_W-1:0]         vec_data;
    logic                      w_valid;
    logic                      w_ready;
    logic [LANES*DATA_W-1:0]   w_data;
    logic [LANES*DATA_W-1:0]   b_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [LANES*DATA_W-1:0]   res_data;
    logic [IDX_W-1:0]          res_idx;

    modport slave (
        input  start, reuse_vec, vec_valid, vec_data, w_valid, w_data, b_data, res_ready,
        output busy, done, vec_ready, w_ready, res_valid, res_data, res_idx
    );

    modport master (
        output start, reuse_vec, vec_valid, vec_data, w_valid, w_data, b_data, res_ready,
        input  busy, done, vec_ready, w_ready, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/lstm_matvec_engine.sv
// Streaming W*x + b engine: buffers x once, then runs LANES MAC lanes per row
// tile and emits each tile rounded (half toward +inf) and saturated.
module lstm_matvec_engine #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IN_LEN  = 100,
    parameter int OUT_LEN = 400,
    parameter int LANES   = 20,
    parameter int ACC_W   = 2*DATA_W + $clog2(IN_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    lstm_matvec_engine_if.slave bus
);
    localparam int TILES  = OUT_LEN / LANES;
    localparam int IDX_W  = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int K_W    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int PROD_W = 2*DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [IDX_W-1:0]          t_q, t_d;
    logic signed [DATA_W-1:0]  vbuf_q [IN_LEN];
    logic signed [DATA_W-1:0]  vbuf_d [IN_LEN];
    logic signed [ACC_W-1:0]   acc_q  [LANES];
    logic signed [ACC_W-1:0]   acc_d  [LANES];
    logic signed [ACC_W-1:0]   sum_c  [LANES];
    logic [LANES*DATA_W-1:0]   res_data_q, res_data_d, res_sat;
    logic [IDX_W-1:0]          res_idx_q, res_idx_d;
    logic                      res_valid_q, res_valid_d;

    logic k_last, t_last, w_ready_c, w_hs, res_hs;

    assign k_last    = (k_q == K_W'(IN_LEN-1));
    assign t_last    = (t_q == IDX_W'(TILES-1));
    assign res_hs    = res_valid_q && bus.res_ready;
    // Only the tile-closing beat needs a free result register.
    assign w_ready_c = (state_q == S_MAC) && (!k_last || !res_valid_q || bus.res_ready);
    assign w_hs      = w_ready_c && bus.w_valid;

    always_comb begin : datapath
        logic signed [DATA_W-1:0] w_l, b_l;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  base, rnd, shr;
        w_l     = '0;
        b_l     = '0;
        prod    = '0;
        base    = '0;
        rnd     = '0;
        shr     = '0;
        res_sat = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_l      = bus.w_data[l*DATA_W +: DATA_W];
            b_l      = bus.b_data[l*DATA_W +: DATA_W];
            prod     = w_l * vbuf_q[k_q];
            base     = (k_q == '0) ? ({{(ACC_W-DATA_W){b_l[DATA_W-1]}}, b_l} << FRAC_W) : acc_q[l];
            sum_c[l] = base + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            rnd      = sum_c[l] + RND_HALF;
            shr      = rnd >>> FRAC_W;
            if (shr > SAT_MAX)
                res_sat[l*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            else if (shr < SAT_MIN)
                res_sat[l*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            else
                res_sat[l*DATA_W +: DATA_W] = shr[DATA_W-1:0];
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        k_d         = k_q;
        t_d         = t_q;
        vbuf_d      = vbuf_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = res_valid_q && !res_hs;
        case (state_q)
            S_IDLE: if (bus.start) begin
                k_d     = '0;
                t_d     = '0;
                state_d = bus.reuse_vec ? S_MAC : S_LOAD;
            end
            S_LOAD: if (bus.vec_valid) begin
                vbuf_d[k_q] = bus.vec_data;
                if (k_last) begin
                    k_d     = '0;
                    state_d = S_MAC;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_MAC: if (w_hs) begin
                acc_d = sum_c;
                if (k_last) begin
                    k_d         = '0;
                    t_d         = t_q + 1'b1;
                    res_data_d  = res_sat;
                    res_idx_d   = t_q;
                    res_valid_d = 1'b1;
                    if (t_last) state_d = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: if (!res_valid_q || bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE) && (!res_valid_q || bus.res_ready);
        bus.vec_ready = (state_q == S_LOAD);
        bus.w_ready   = w_ready_c;
        bus.res_valid = res_valid_q;
        bus.res_data  = res_data_q;
        bus.res_idx   = res_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            t_q         <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            for (int unsigned i = 0; i < IN_LEN; i++) vbuf_q[i] <= '0;
            for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            vbuf_q      <= vbuf_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_lstm_matvec_engine.sv
// Directed bench for lstm_matvec_engine (4-wide lanes, 4-column vector, 2 tiles)
// with hand-computed expected tiles.
module tb_lstm_matvec_engine;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 8;
    localparam int LANES   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lstm_matvec_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(1)) bus();

    lstm_matvec_engine #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_LEN(IN_LEN),
        .OUT_LEN(OUT_LEN), .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [15:0] xmem [IN_LEN];
    logic [63:0] wmem [2][IN_LEN];
    logic [63:0] bmem [2];

    int          cyc = 0;
    logic [63:0] got_data [4];
    logic        got_idx  [4];
    int          got_n, done_n, vr_n, first_vec_cyc, last_res_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (bus.res_valid && bus.res_ready && got_n < 4) begin
            got_data[got_n] = bus.res_data;
            got_idx[got_n]  = bus.res_idx;
            got_n++;
        end
        if (bus.done) done_n++;
        if (bus.vec_ready) vr_n++;
        if (bus.vec_valid && bus.vec_ready && first_vec_cyc < 0) first_vec_cyc = cyc;
        if (bus.res_valid && bus.res_idx == 1'b1 && last_res_cyc < 0) last_res_cyc = cyc;
    end

    task automatic clear_mon();
        got_n = 0; done_n = 0; vr_n = 0; first_vec_cyc = -1; last_res_cyc = -1;
    endtask

    task automatic set_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        xmem[0] = a; xmem[1] = b; xmem[2] = c; xmem[3] = d;
    endtask

    task automatic set_uniform(input logic [15:0] w, input logic [15:0] b);
        for (int t = 0; t < 2; t++) begin
            bmem[t] = {4{b}};
            for (int k = 0; k < IN_LEN; k++) wmem[t][k] = {4{w}};
        end
    endtask

    // Lane 0 weights only at k==0 and a tile-dependent lane-0 bias, so lane
    // order, column indexing and tile sequencing all show up in the result.
    task automatic set_distinct();
        set_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        for (int t = 0; t < 2; t++) begin
            bmem[t] = {16'h0000, 16'h0000, 16'h0010, (t == 1) ? 16'h0100 : 16'h0000};
            for (int k = 0; k < IN_LEN; k++)
                wmem[t][k] = {16'hFF00, 16'h0040, 16'h0100, (k == 0) ? 16'h0100 : 16'h0000};
        end
    endtask

    task automatic start_job(input logic reuse);
        bus.start = 1'b1;
        bus.reuse_vec = reuse;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.reuse_vec = 1'b0;
        #1;
        check("start_busy", bus.busy, 1);
        check("start_vec_ready", bus.vec_ready, !reuse);
        check("start_w_ready", bus.w_ready, reuse);
        @(negedge clk);
    endtask

    task automatic drive_vec(input logic [15:0] d);
        logic ok, rdy;
        ok = 1'b0;
        bus.vec_valid = 1'b1;
        bus.vec_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1 rdy = bus.vec_ready;
            @(posedge clk);
            @(negedge clk);
            ok = rdy;
        end
        bus.vec_valid = 1'b0;
        if (!ok) check("vec_timeout", 0, 1);
    endtask

    task automatic drive_w(input logic [63:0] w, input logic [63:0] b);
        logic ok, rdy;
        ok = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data  = w;
        bus.b_data  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1 rdy = bus.w_ready;
            @(posedge clk);
            @(negedge clk);
            ok = rdy;
        end
        bus.w_valid = 1'b0;
        if (!ok) check("w_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 30 && bus.busy; n++) @(negedge clk);
        if (bus.busy) check("idle_timeout", 0, 1);
    endtask

    task automatic run_job(input string name, input logic reuse, input logic [63:0] e0, input logic [63:0] e1);
        clear_mon();
        start_job(reuse);
        if (!reuse) for (int k = 0; k < IN_LEN; k++) drive_vec(xmem[k]);
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < IN_LEN; k++) drive_w(wmem[t][k], bmem[t]);
        wait_idle();
        check({name, "_count"}, got_n, 2);
        check({name, "_t0"}, got_data[0], e0);
        check({name, "_idx0"}, got_idx[0], 0);
        check({name, "_t1"}, got_data[1], e1);
        check({name, "_idx1"}, got_idx[1], 1);
        check({name, "_done"}, done_n, 1);
    endtask

    localparam logic [63:0] BASIC = {4{16'h0240}};
    localparam logic [63:0] DT0   = {16'hF600, 16'h0280, 16'h0A10, 16'h0100};
    localparam logic [63:0] DT1   = {16'hF600, 16'h0280, 16'h0A10, 16'h0200};

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_done"}, bus.done, 0);
        check({name, "_vec_ready"}, bus.vec_ready, 0);
        check({name, "_w_ready"}, bus.w_ready, 0);
        check({name, "_res_valid"}, bus.res_valid, 0);
        check({name, "_res_data"}, bus.res_data, 0);
        check({name, "_res_idx"}, bus.res_idx, 0);
    endtask

    initial begin
        bus.start = 0; bus.reuse_vec = 0; bus.vec_valid = 0; bus.vec_data = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.b_data = '0; bus.res_ready = 1'b1;
        clear_mon();
        #12;
        check_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        set_x(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_uniform(16'h0080, 16'h0040);
        run_job("basic", 1'b0, BASIC, BASIC);
        check("basic_latency", last_res_cyc - first_vec_cyc, 12);

        run_job("reuse", 1'b1, BASIC, BASIC);
        check("reuse_vec_ready", vr_n, 0);

        set_distinct();
        run_job("lanes", 1'b0, DT0, DT1);

        set_x(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_uniform(16'h7FFF, 16'h0000);
        run_job("sat_pos", 1'b0, {4{16'h7FFF}}, {4{16'h7FFF}});
        set_uniform(16'h8000, 16'h0000);
        run_job("sat_neg", 1'b0, {4{16'h8000}}, {4{16'h8000}});

        set_x(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        set_uniform(16'h0080, 16'h0000);
        run_job("rnd_pos", 1'b0, {4{16'h0001}}, {4{16'h0001}});
        set_uniform(16'hFF80, 16'h0000);
        run_job("rnd_neg", 1'b0, {4{16'h0000}}, {4{16'h0000}});

        // Backpressure: tile 0 held in the result register while tile 1 runs.
        set_distinct();
        clear_mon();
        bus.res_ready = 1'b0;
        start_job(1'b0);
        for (int k = 0; k < IN_LEN; k++) drive_vec(xmem[k]);
        for (int k = 0; k < IN_LEN; k++) drive_w(wmem[0][k], bmem[0]);
        #1;
        check("bp_t0_valid", bus.res_valid, 1);
        check("bp_t0_data", bus.res_data, DT0);
        for (int k = 0; k < IN_LEN-1; k++) drive_w(wmem[1][k], bmem[1]);
        bus.w_valid = 1'b1; bus.w_data = wmem[1][3]; bus.b_data = bmem[1];
        #1 check("bp_w_ready_low", bus.w_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        check("bp_hold_w_ready", bus.w_ready, 0);
        check("bp_hold_data", bus.res_data, DT0);
        check("bp_hold_idx", bus.res_idx, 0);
        check("bp_hold_valid", bus.res_valid, 1);
        @(negedge clk);
        bus.res_ready = 1'b1;
        #1 check("bp_release_w_ready", bus.w_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.w_valid = 1'b0;
        #1;
        check("bp_t1_valid", bus.res_valid, 1);
        check("bp_t1_idx", bus.res_idx, 1);
        check("bp_t1_data", bus.res_data, DT1);
        check("bp_done_now", bus.done, 1);
        wait_idle();
        check("bp_count", got_n, 2);
        check("bp_got_t0", got_data[0], DT0);
        check("bp_got_t1", got_data[1], DT1);
        check("bp_done_once", done_n, 1);

        // Asynchronous reset in the middle of tile 0.
        set_x(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_uniform(16'h0080, 16'h0040);
        clear_mon();
        start_job(1'b0);
        for (int k = 0; k < IN_LEN; k++) drive_vec(xmem[k]);
        for (int k = 0; k < 2; k++) drive_w(wmem[0][k], bmem[0]);
        bus.w_valid = 1'b1; bus.w_data = wmem[0][2]; bus.b_data = bmem[0];
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        bus.w_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        run_job("zero_buf", 1'b1, {4{16'h0040}}, {4{16'h0040}});
        run_job("after_rst", 1'b0, BASIC, BASIC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
